mac_accum: RTL

Dot-product accumulator that sits directly upstream of the ReLU/int8 saturation stage. It multiplies VEC_LEN pairs of signed int8 activations and weights and adds them to a signed bias. It then requantizes the sum with a rounding arithmetic right shift and saturates it to a signed WIDTH_OUT value. Each completed vector produces one single-cycle valid_out pulse whose data feeds the ReLU `data_in`/`valid_in` pair directly.

---
 rtl/mac_accum.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mac_accum.sv
// mac_accum: signed int8 dot-product accumulator with a requantizing output.
//
// A vector starts when start is seen in IDLE. The accumulator is loaded with
// bias, then VEC_LEN (act_in * wgt_in) terms are accepted while in ACCUM.
// Each accepted product is registered and added to the accumulator one
// cycle later. When the last product has been added, the sum is requantized
// with a round-half-up arithmetic right shift by SHIFT, saturated to
// WIDTH_OUT bits, and presented on data_out with a one-cycle valid_out pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, synchronous release
//   start      begin a new vector (sampled only in IDLE)
//   bias       signed WIDTH_ACC, loaded into the accumulator on start
//   valid_in   act_in/wgt_in carry a term this cycle
//   act_in     signed WIDTH_IN activation
//   wgt_in     signed WIDTH_IN weight
//   ready_in   terms are accepted this cycle (ACCUM only)
//   busy       high in every state except IDLE
//   data_out   signed WIDTH_OUT requantized result, held until the next one
//   valid_out  one-cycle pulse marking a new data_out
module mac_accum #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_ACC = 32,
  parameter int WIDTH_OUT = 16,
  parameter int VEC_LEN   = 16,
  parameter int SHIFT     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [WIDTH_ACC-1:0] bias,
  input  logic                        valid_in,
  input  logic signed [WIDTH_IN-1:0]  act_in,
  input  logic signed [WIDTH_IN-1:0]  wgt_in,
  output logic                        ready_in,
  output logic                        busy,
  output logic signed [WIDTH_OUT-1:0] data_out,
  output logic                        valid_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

  // Rounding constant 2^(SHIFT-1), or zero when there is no shift.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WIDTH_ACC:0] ROUND_C =
    (SHIFT > 0) ? ((WIDTH_ACC+1)'(1) << RND_SH) : '0;

  // Saturation bounds expressed in the WIDTH_ACC+1 requantization width.
  localparam logic signed [WIDTH_ACC:0] OUT_MAX =
    {{(WIDTH_ACC+2-WIDTH_OUT){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [WIDTH_ACC:0] OUT_MIN = ~OUT_MAX;

  state_t                       state_reg, state_next;
  logic [CNT_W-1:0]             cnt_reg;
  logic signed [WIDTH_ACC-1:0]  acc_reg;
  logic signed [WIDTH_ACC-1:0]  prod_reg;
  logic                         prod_v_reg;

  logic                         accept;
  logic                         last_term;
  logic signed [2*WIDTH_IN-1:0] prod_full;
  logic signed [WIDTH_ACC:0]    rounded;
  logic signed [WIDTH_ACC:0]    shifted;
  logic signed [WIDTH_OUT-1:0]  sat_val;

  assign accept    = (state_reg == ACCUM) && valid_in;
  assign last_term = accept && (cnt_reg == LAST_IDX);
  assign prod_full = act_in * wgt_in;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    ready_in   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        ready_in = 1'b1;
        if (last_term) state_next = DRAIN;
      end
      DRAIN:   state_next = EMIT;
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requantization: sign-extend by one bit so the rounding add cannot wrap,
  // then floor-shift and clamp into the output range.
  assign rounded = {acc_reg[WIDTH_ACC-1], acc_reg} + ROUND_C;
  assign shifted = rounded >>> SHIFT;

  always_comb begin
    if (shifted > OUT_MAX)
      sat_val = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    else if (shifted < OUT_MIN)
      sat_val = {1'b1, {(WIDTH_OUT-1){1'b0}}};
    else
      sat_val = shifted[WIDTH_OUT-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      prod_reg   <= '0;
      prod_v_reg <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      prod_v_reg <= accept;
      valid_out  <= (state_reg == EMIT);

      if (accept) begin
        prod_reg <= WIDTH_ACC'(prod_full);
        cnt_reg  <= cnt_reg + CNT_W'(1);
      end

      // A start load and a pending product never coincide: the last product
      // is added in DRAIN, two cycles before the block can be back in IDLE.
      if ((state_reg == IDLE) && start) begin
        acc_reg <= bias;
        cnt_reg <= '0;
      end else if (prod_v_reg) begin
        acc_reg <= acc_reg + prod_reg;
      end

      if (state_reg == EMIT) data_out <= sat_val;
    end
  end

endmodule
